// File: rtl/ycrcb_conv_sched.sv
// ycrcb_conv_sched: round-robin scheduler sharing one fixed-latency RGB->YCrCb converter
//   clk_in / rst_n_in          : clock, asynchronous active-low reset
//   req_valid_in/req_ready_out : per-requester pixel handshake (ready is one-hot or zero)
//   req_{r,g,b}_in             : per-requester 10-bit components, packed NUM_REQ x 10
//   conv_{r,g,b}_out           : registered converter inputs
//   conv_{y,cr,cb}_in          : converter outputs, CONV_LAT edges after the inputs change
//   out_*                      : first-word fall-through result FIFO head with valid/ready
module ycrcb_conv_sched #(
    parameter  int NUM_REQ    = 2,
    parameter  int CONV_LAT   = 3,
    parameter  int FIFO_DEPTH = 8,
    localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    output logic [NUM_REQ-1:0]    req_ready_out,
    input  logic [NUM_REQ*10-1:0] req_r_in,
    input  logic [NUM_REQ*10-1:0] req_g_in,
    input  logic [NUM_REQ*10-1:0] req_b_in,
    output logic [9:0]            conv_r_out,
    output logic [9:0]            conv_g_out,
    output logic [9:0]            conv_b_out,
    input  logic [9:0]            conv_y_in,
    input  logic [9:0]            conv_cr_in,
    input  logic [9:0]            conv_cb_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [ID_W-1:0]       out_id_out,
    output logic [9:0]            out_y_out,
    output logic [9:0]            out_cr_out,
    output logic [9:0]            out_cb_out
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = ID_W + 30;

    logic [ID_W-1:0] last_q, grant;
    logic            found, issue, push, pop;
    logic [CW-1:0]   credits_q, credits_d, cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, rd_q;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [CONV_LAT:0] tag_v_q;
    logic [ID_W-1:0] tag_id_q [CONV_LAT+1];
    logic [9:0]      conv_r_q, conv_g_q, conv_b_q;

    // First valid requester at or after last_grant+1, wrapping.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid_in[(int'(last_q) + k) % NUM_REQ]) begin
                grant = ID_W'((int'(last_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    // Readiness looks only at registered credits, so a same-cycle pop cannot enable an issue.
    assign req_ready_out = (rst_n_in && found && credits_q != '0) ? NUM_REQ'(1) << grant : '0;
    assign issue         = |(req_valid_in & req_ready_out);
    assign push          = tag_v_q[CONV_LAT];
    assign pop           = out_valid_out && out_ready_in;
    assign credits_d     = credits_q - CW'(issue) + CW'(pop);
    assign cnt_d         = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_q    <= ID_W'(NUM_REQ - 1);
            credits_q <= CW'(FIFO_DEPTH);
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            tag_v_q   <= '0;
            conv_r_q  <= '0;
            conv_g_q  <= '0;
            conv_b_q  <= '0;
        end else begin
            credits_q <= credits_d;
            cnt_q     <= cnt_d;
            tag_v_q   <= {tag_v_q[CONV_LAT-1:0], issue};
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (issue) begin
                last_q   <= grant;
                conv_r_q <= req_r_in[grant*10 +: 10];
                conv_g_q <= req_g_in[grant*10 +: 10];
                conv_b_q <= req_b_in[grant*10 +: 10];
            end
        end
    end

    // Tag ids and FIFO storage carry no reset; only their valid bits and pointers matter.
    always_ff @(posedge clk_in) begin
        tag_id_q[0] <= grant;
        for (int s = 1; s <= CONV_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
        if (push) mem_q[wr_q] <= {tag_id_q[CONV_LAT], conv_y_in, conv_cr_in, conv_cb_in};
    end

    always_ff @(posedge clk_in) begin
        if (rst_n_in) begin
            assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
            assert (credits_q <= CW'(FIFO_DEPTH));
        end
    end

    assign conv_r_out    = conv_r_q;
    assign conv_g_out    = conv_g_q;
    assign conv_b_out    = conv_b_q;
    assign out_valid_out = cnt_q != '0;
    assign {out_id_out, out_y_out, out_cr_out, out_cb_out} = out_valid_out ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_ycrcb_conv_sched.sv
// tb_ycrcb_conv_sched: directed bench with a converter model and an issue-order scoreboard
module tb_ycrcb_conv_sched;
    logic        clk_in, rst_n_in;
    logic [1:0]  req_valid_in, req_ready_out;
    logic [19:0] req_r_in, req_g_in, req_b_in;
    logic [9:0]  conv_r_out, conv_g_out, conv_b_out;
    logic [9:0]  conv_y_in, conv_cr_in, conv_cb_in;
    logic        out_valid_out, out_ready_in;
    logic [0:0]  out_id_out;
    logic [9:0]  out_y_out, out_cr_out, out_cb_out;
    logic [29:0] p1, p2, p3;
    logic [30:0] sb [$];
    int n_assert = 0, n_fail = 0, n_issue = 0;

    ycrcb_conv_sched dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_r_in(req_r_in), .req_g_in(req_g_in), .req_b_in(req_b_in),
        .conv_r_out(conv_r_out), .conv_g_out(conv_g_out), .conv_b_out(conv_b_out),
        .conv_y_in(conv_y_in), .conv_cr_in(conv_cr_in), .conv_cb_in(conv_cb_in),
        .out_valid_out(out_valid_out), .out_ready_in(out_ready_in), .out_id_out(out_id_out),
        .out_y_out(out_y_out), .out_cr_out(out_cr_out), .out_cb_out(out_cb_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Fixed-point RGB->YCrCb, 10-bit wrap, no chroma offset.
    function automatic logic [29:0] cvt(input logic [9:0] r, g, b);
        int ri, gi, bi, y, cr, cb;
        ri = int'(r); gi = int'(g); bi = int'(b);
        y  = (306 * ri + 601 * gi + 116 * bi) >>> 10;
        cr = (512 * ri - 429 * gi - 83 * bi) >>> 10;
        cb = (-173 * ri - 339 * gi + 512 * bi) >>> 10;
        return {y[9:0], cr[9:0], cb[9:0]};
    endfunction

    // Three-stage converter model.
    always @(posedge clk_in) begin
        p1 <= cvt(conv_r_out, conv_g_out, conv_b_out);
        p2 <= p1;
        p3 <= p2;
    end
    assign {conv_y_in, conv_cr_in, conv_cb_in} = p3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; samples before the posedge.
    task automatic cyc();
        logic [30:0] e;
        #2;
        check("ready_onehot0", 32'($onehot0(req_ready_out)), 1);
        for (int k = 0; k < 2; k++) begin
            if (req_valid_in[k] && req_ready_out[k]) begin
                sb.push_back({1'(k), cvt(req_r_in[k*10 +: 10], req_g_in[k*10 +: 10], req_b_in[k*10 +: 10])});
                n_issue++;
            end
        end
        if (out_valid_out && out_ready_in) begin
            if (sb.size() == 0) check("sb_unexpected_result", 1, 0);
            else begin
                e = sb.pop_front();
                check("sb_id", 32'(out_id_out), 32'(e[30]));
                check("sb_data", 32'({out_y_out, out_cr_out, out_cb_out}), 32'(e[29:0]));
            end
        end
        @(negedge clk_in);
    endtask

    task automatic wait_out(input int max, output int n);
        n = 0;
        while (!out_valid_out && n < max) begin
            cyc();
            n++;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            cyc();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    task automatic new_pix(input int k);
        req_r_in[k*10 +: 10] = 10'($urandom);
        req_g_in[k*10 +: 10] = 10'($urandom);
        req_b_in[k*10 +: 10] = 10'($urandom);
    endtask

    initial begin
        int n, c0, g;
        rst_n_in = 1'b0; req_valid_in = '0; out_ready_in = 1'b0;
        req_r_in = '0; req_g_in = '0; req_b_in = '0;
        repeat (2) @(negedge clk_in);
        check("rst_valid", 32'(out_valid_out), 0);
        check("rst_ready", 32'(req_ready_out), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_valid", 32'(out_valid_out), 0);
        check("post_rst_id", 32'(out_id_out), 0);
        check("post_rst_data", 32'({out_y_out, out_cr_out, out_cb_out}), 0);
        check("post_rst_conv", 32'({conv_r_out, conv_g_out, conv_b_out}), 0);
        // single white pixel on requester 0
        out_ready_in = 1'b1;
        req_valid_in = 2'b01;
        req_r_in[9:0] = 10'd1023; req_g_in[9:0] = 10'd1023; req_b_in[9:0] = 10'd1023;
        #1 check("first_grant_req0", 32'(req_ready_out), 1);
        cyc();
        req_valid_in = '0;
        check("conv_r_held", 32'(conv_r_out), 1023);
        wait_out(20, n);
        check("latency", n, 4);
        check("white_id", 32'(out_id_out), 0);
        check("white_y", 32'(out_y_out), 1022);
        check("white_cr", 32'(out_cr_out), 0);
        check("white_cb", 32'(out_cb_out), 0);
        cyc();
        check("white_one_cycle", 32'(out_valid_out), 0);
        // requester 1: red then black
        req_valid_in = 2'b10;
        req_r_in[19:10] = 10'd1023; req_g_in[19:10] = '0; req_b_in[19:10] = '0;
        #1 check("req1_grant_a", 32'(req_ready_out), 2);
        cyc();
        req_r_in[19:10] = '0;
        #1 check("req1_grant_b", 32'(req_ready_out), 2);
        cyc();
        req_valid_in = '0;
        wait_out(20, n);
        check("red_id", 32'(out_id_out), 1);
        check("red_y", 32'(out_y_out), 305);
        check("red_cr", 32'(out_cr_out), 511);
        check("red_cb", 32'(out_cb_out), 851);
        cyc();
        check("black_valid", 32'(out_valid_out), 1);
        check("black_id", 32'(out_id_out), 1);
        check("black_data", 32'({out_y_out, out_cr_out, out_cb_out}), 0);
        cyc();
        check("black_one_cycle", 32'(out_valid_out), 0);
        // both requesters continuously valid: grants alternate from 0
        new_pix(0); new_pix(1);
        req_valid_in = 2'b11;
        g = 0;
        for (int i = 0; i < 12; i++) begin
            #1 check("rr_grant", 32'(req_ready_out), 32'(1 << g));
            cyc();
            new_pix(g);
            g ^= 1;
        end
        req_valid_in = '0;
        drain(30);
        // backpressure: exactly FIFO_DEPTH issues, then blocked
        out_ready_in = 1'b0;
        req_valid_in = 2'b11;
        c0 = n_issue;
        repeat (20) cyc();
        check("fill_issues", n_issue - c0, 8);
        check("fill_blocked", 32'(req_ready_out), 0);
        check("fill_valid", 32'(out_valid_out), 1);
        out_ready_in = 1'b1;
        #1 check("pop_no_same_cycle_issue", 32'(req_ready_out), 0);
        cyc();
        #1 check("reissue_after_pop", 32'(|req_ready_out), 1);
        repeat (10) cyc();
        req_valid_in = '0;
        drain(40);
        // reset with 3 tags in flight and 2 FIFO entries
        out_ready_in = 1'b0;
        new_pix(0);
        req_valid_in = 2'b01;
        repeat (5) begin
            cyc();
            new_pix(0);
        end
        req_valid_in = '0;
        cyc();
        check("pre_rst_valid", 32'(out_valid_out), 1);
        #1 rst_n_in = 1'b0;
        #1 check("async_clear_valid", 32'(out_valid_out), 0);
        check("async_clear_id", 32'(out_id_out), 0);
        check("async_clear_data", 32'({out_y_out, out_cr_out, out_cb_out}), 0);
        sb.delete();
        cyc();
        rst_n_in = 1'b1;
        out_ready_in = 1'b1;
        repeat (10) begin
            cyc();
            check("no_stale_result", 32'(out_valid_out), 0);
        end
        out_ready_in = 1'b0;
        req_valid_in = 2'b01;
        c0 = n_issue;
        repeat (15) cyc();
        check("post_rst_issues", n_issue - c0, 8);
        check("post_rst_blocked", 32'(req_ready_out), 0);
        req_valid_in = '0;
        out_ready_in = 1'b1;
        drain(40);
        check("final_valid", 32'(out_valid_out), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ycrcb_conv_sched.md
# ycrcb_conv_sched

Round-robin scheduler that shares one fixed-latency RGB→YCrCb converter (`rgb_conv`, 3-cycle pipeline, no stall input) among NUM_REQ pixel requesters. It accepts pixels over valid/ready and drives the converter's inputs. It tracks each in-flight pixel with a tag pipeline and collects results in an output FIFO with a shared valid/ready port. A credit counter guarantees that every issued pixel has a reserved FIFO slot, so results are never dropped.

## Interface
- NUM_REQ, 2: number of requesters (2..8); ID_W = max(1, $clog2(NUM_REQ)).
- CONV_LAT, 3: converter latency in clock edges from input change to output.
- FIFO_DEPTH, 8: output FIFO entries (power of 2, ≥ CONV_LAT+1).
- clk_in  input  1  single clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- req_valid_in  input  NUM_REQ  per-requester pixel valid.
- req_ready_out  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_r_in, req_g_in, req_b_in  input  NUM_REQ×10 each  per-requester pixel components.
- conv_r_out, conv_g_out, conv_b_out  output  10 each  registered converter inputs.
- conv_y_in, conv_cr_in, conv_cb_in  input  10 each  converter outputs.
- out_valid_out  output  1  FIFO head valid.
- out_ready_in  input  1  downstream accept.
- out_id_out  output  ID_W  requester index of the head result.
- out_y_out, out_cr_out, out_cb_out  output  10 each  head result.

## Operation
- Credits: register, reset to FIFO_DEPTH.
  - Decrement on issue; increment on FIFO pop (out_valid_out && out_ready_in).
  - Both in one cycle: net unchanged.
  - Invariant: credits + in-flight tags + FIFO occupancy = FIFO_DEPTH.
- Arbitration: combinational round-robin.
  - Search starts at last_grant+1 (mod NUM_REQ) and takes the first requester with valid set.
  - last_grant resets to NUM_REQ−1, so requester 0 has first priority.
  - last_grant updates only on issue.
- req_ready_out[i] = (credits ≠ 0) && (grant == i). Readiness uses the registered credits; a pop in the same cycle does not enable an issue that cycle.
- Issue: req_valid_in[i] && req_ready_out[i].
  - On that edge, conv_*_out ← req_*_in[i] and tag stage 0 ← {valid=1, id=i}.
  - With no issue, conv_*_out hold their value and stage 0 valid ← 0.
- Requester rule: while valid && !ready, data must stay stable. The scheduler never revokes a grant mid-cycle.
- Tag pipeline: stages 0..CONV_LAT shift every cycle unconditionally.
  - When stage CONV_LAT is valid, {id, conv_y_in, conv_cr_in, conv_cb_in} is written to the FIFO on the next edge.
  - Overflow is impossible by the credit invariant; an assertion must flag it.
- Output FIFO:
  - First-word fall-through, in issue order.
  - out_valid_out = occupancy ≠ 0.
  - out_id_out and out data are 0 whenever out_valid_out = 0.
  - Push and pop in the same cycle are both allowed, including when full (pop frees a slot) and when empty-with-push (push only; no bypass).
- Converter data registers are not reset. Stale converter outputs are ignored because their tags are invalid.

## Timing
- Reset values:
  - req_ready_out = 0, conv_*_out = 0, out_valid_out = 0, out_id_out = 0, out_y/cr/cb_out = 0.
  - credits = FIFO_DEPTH, all tags invalid, FIFO empty, last_grant = NUM_REQ−1.
- Reset mid-operation:
  - All in-flight and queued results are discarded; outputs clear asynchronously.
  - No result appears after release until a new issue plus CONV_LAT+1 cycles.
- Latency: issue at edge E0, then conv_*_out valid after E0, converter output after E0+CONV_LAT, FIFO write at E0+CONV_LAT+1. out_valid_out is high after that edge: 4 cycles at default.
- Throughput: one issue per cycle while credits ≠ 0. With out_ready_in held high, steady state is 1 pixel per cycle.
- With out_ready_in = 0, exactly FIFO_DEPTH issues are accepted, then req_ready_out = 0 until a pop.

## Test plan
- Single pixel on req 0, R=G=B=1023, out_ready_in=1 (real rgb_conv attached) -> out_valid_out after 4 cycles with id 0, Y=1022, Cr=0, Cb=0, high for one cycle.
- Req 1 alone, R=1023, G=B=0, then R=G=B=0 -> in order: Y=305, Cr=511, Cb=851; then Y=0, Cr=0, Cb=0; both with id 1.
- Both requesters continuously valid, out_ready_in=1 -> grants alternate 0,1,0,1 from reset, one per cycle; out_id_out alternates identically with 4-cycle offset.
- out_ready_in=0, both valid -> exactly 8 issues, then req_ready_out=0 indefinitely. Raise out_ready_in -> 8 results in issue order; first pop re-enables issue one cycle later; credits never exceed 8.
- Credits=0 with a pop and a waiting requester in the same cycle -> no issue that cycle; issue on the next cycle.
- rst_n_in low for 1 cycle with 3 tags in flight and 2 FIFO entries -> out_valid_out drops immediately. No result emerges for the next 10 cycles without new issues, and 8 new issues are accepted afterward.
